// File: rtl/lpddr_pkg.sv
// Shared MCB command encodings, UART framing bytes and FSM state types
// for the LPDDR-to-UART readback path.
package lpddr_pkg;

  localparam logic [2:0] MCB_CMD_WRITE    = 3'b000;
  localparam logic [2:0] MCB_CMD_READ     = 3'b001;
  localparam logic [2:0] MCB_CMD_WRITE_AP = 3'b010;
  localparam logic [2:0] MCB_CMD_READ_AP  = 3'b011;
  localparam logic [2:0] MCB_CMD_REFRESH  = 3'b100;

  localparam logic [7:0] FRAME_HDR = 8'd1;
  localparam logic [7:0] FRAME_TRL = 8'd98;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT_DATA,
    ST_POP,
    ST_SEND,
    ST_WAIT_TX,
    ST_NEXT,
    ST_HDR,
    ST_TRL
  } rb_state_t;

  typedef enum logic {
    SER_IDLE,
    SER_WAIT
  } ser_state_t;

endpackage

// File: rtl/lpddr_uart_readback_word_serializer.sv
// Loads one 32-bit word and emits its bytes LSB-first over the uart_tx
// tx_start/tx_done_tick handshake; last_idx_i selects 1..4 bytes.
module word_serializer
  import lpddr_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        abort_i,
  input  logic        load_i,
  input  logic [31:0] data_i,
  input  logic [1:0]  last_idx_i,
  input  logic        tx_done_tick_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_start_o,
  output logic        done_o
);

  ser_state_t  state_q;
  logic [31:0] shift_q;
  logic [1:0]  idx_q;
  logic [1:0]  last_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= SER_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      last_q     <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      if (abort_i) begin
        state_q <= SER_IDLE;
      end else begin
        unique case (state_q)
          SER_IDLE: if (load_i) begin
            shift_q    <= data_i;
            idx_q      <= '0;
            last_q     <= last_idx_i;
            tx_data_q  <= data_i[7:0];
            tx_start_q <= 1'b1;
            state_q    <= SER_WAIT;
          end
          // A tick coinciding with our own tx_start cannot belong to this byte.
          SER_WAIT: if (tx_done_tick_i && !tx_start_q) begin
            if (idx_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= SER_IDLE;
            end else begin
              idx_q      <= 2'(idx_q + 2'd1);
              shift_q    <= shift_q >> 8;
              tx_data_q  <= shift_q[15:8];
              tx_start_q <= 1'b1;
            end
          end
          default: state_q <= SER_IDLE;
        endcase
      end
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_start_o = tx_start_q;
  assign done_o     = done_q;

endmodule

// File: rtl/lpddr_uart_readback.sv
// Issues MCB read commands for a block of words and streams them to uart_tx.
// Optional framing bytes around the dump: define READBACK_FRAMING_EN.
module lpddr_uart_readback
  import lpddr_pkg::*;
#(
  parameter int unsigned BURST_LEN = 32,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [29:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cmd_clk,
  output logic             cmd_en,
  output logic [2:0]       cmd_instr,
  output logic [5:0]       cmd_bl,
  output logic [29:0]      cmd_byte_addr,
  input  logic             cmd_full,
  input  logic             cmd_empty,
  output logic             rd_clk,
  output logic             rd_en,
  input  logic [31:0]      rd_data,
  input  logic             rd_empty,
  input  logic [6:0]       rd_count,
  input  logic             rd_overflow,
  input  logic             rd_error,
  output logic [7:0]       tx_data_in,
  output logic             tx_start,
  input  logic             tx_done_tick
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BURST_LEN);

  rb_state_t        state_q;
  logic [29:0]      addr_q;
  logic [CNT_W-1:0] remaining_q;
  logic [6:0]       burst_q;
  logic [6:0]       burst_left_q;
  logic [6:0]       burst_d;
  logic             busy_q, done_q, error_q;
  logic             cmd_en_q, rd_en_q, ser_load_q;
  logic [5:0]       cmd_bl_q;
  logic [29:0]      cmd_addr_q;
  logic             err_in, fault, ser_done;
  logic [31:0]      ser_data;
  logic [1:0]       ser_last;
  logic             unused_inputs;

  assign unused_inputs = ^{cmd_empty, rd_count};

  always_comb begin
    burst_d = (remaining_q > BURST_MAX) ? 7'(BURST_LEN) : 7'(remaining_q);
  end

  assign err_in = (state_q != ST_IDLE) && (rd_overflow || rd_error);
`ifdef READBACK_FRAMING_EN
  // The trailer is still owed after an abort, so a fault cannot re-abort it.
  assign fault = err_in && (state_q != ST_TRL);
`else
  assign fault = err_in;
`endif

  always_comb begin
    ser_data = rd_data;
    ser_last = 2'd3;
`ifdef READBACK_FRAMING_EN
    if (state_q == ST_HDR) begin
      ser_data = {24'd0, FRAME_HDR};
      ser_last = 2'd0;
    end else if (state_q == ST_TRL) begin
      ser_data = {24'd0, FRAME_TRL};
      ser_last = 2'd0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      remaining_q  <= '0;
      burst_q      <= '0;
      burst_left_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cmd_en_q     <= 1'b0;
      cmd_bl_q     <= '0;
      cmd_addr_q   <= '0;
      rd_en_q      <= 1'b0;
      ser_load_q   <= 1'b0;
    end else begin
      cmd_en_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      done_q     <= 1'b0;
      ser_load_q <= 1'b0;
      if (err_in) error_q <= 1'b1;
      if (fault) begin
`ifdef READBACK_FRAMING_EN
        state_q    <= ST_TRL;
        ser_load_q <= 1'b1;
`else
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
`endif
      end else begin
        unique case (state_q)
          ST_IDLE: if (start) begin
            addr_q      <= {base_addr[29:2], 2'b00};
            remaining_q <= word_count;
            error_q     <= 1'b0;
            if (word_count == '0) begin
              done_q <= 1'b1;
            end else begin
              busy_q <= 1'b1;
`ifdef READBACK_FRAMING_EN
              state_q    <= ST_HDR;
              ser_load_q <= 1'b1;
`else
              state_q <= ST_CMD;
`endif
            end
          end
          ST_CMD: if (!cmd_full) begin
            cmd_en_q     <= 1'b1;
            cmd_bl_q     <= 6'(burst_d - 7'd1);
            cmd_addr_q   <= addr_q;
            burst_q      <= burst_d;
            burst_left_q <= burst_d;
            state_q      <= ST_WAIT_DATA;
          end
          // Serializer load is aligned with the pop so it samples the FWFT head.
          ST_WAIT_DATA: if (!rd_empty) begin
            rd_en_q    <= 1'b1;
            ser_load_q <= 1'b1;
            state_q    <= ST_POP;
          end
          ST_POP:     state_q <= ST_SEND;
          ST_SEND:    state_q <= ST_WAIT_TX;
          ST_WAIT_TX: if (ser_done) state_q <= ST_NEXT;
          ST_NEXT: begin
            burst_left_q <= burst_left_q - 7'd1;
            remaining_q  <= remaining_q - 1'b1;
            if (burst_left_q == 7'd1) begin
              addr_q <= addr_q + {21'd0, burst_q, 2'b00};
              if (remaining_q == CNT_W'(1)) begin
`ifdef READBACK_FRAMING_EN
                state_q    <= ST_TRL;
                ser_load_q <= 1'b1;
`else
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
`endif
              end else begin
                state_q <= ST_CMD;
              end
            end else begin
              state_q <= ST_WAIT_DATA;
            end
          end
`ifdef READBACK_FRAMING_EN
          ST_HDR: if (ser_done) state_q <= ST_CMD;
          ST_TRL: if (ser_done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
`endif
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  word_serializer u_ser (
    .clk_i          (clk),
    .reset_i        (reset),
    .abort_i        (fault),
    .load_i         (ser_load_q),
    .data_i         (ser_data),
    .last_idx_i     (ser_last),
    .tx_done_tick_i (tx_done_tick),
    .tx_data_o      (tx_data_in),
    .tx_start_o     (tx_start),
    .done_o         (ser_done)
  );

  assign cmd_clk       = clk;
  assign rd_clk        = clk;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign cmd_en        = cmd_en_q;
  assign cmd_instr     = MCB_CMD_READ;
  assign cmd_bl        = cmd_bl_q;
  assign cmd_byte_addr = cmd_addr_q;
  assign rd_en         = rd_en_q;

endmodule
